// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the gshare branch predictor.
// Holds the 2-bit counter states, default geometry and the index/update functions.
package bp_pkg;

   localparam int unsigned GHR_BITS_DEF     = 4;
   localparam int unsigned BTB_IDX_BITS_DEF = 4;

   typedef enum logic [1:0] {
      CntSnt = 2'b00,
      CntWnt = 2'b01,
      CntWt  = 2'b10,
      CntSt  = 2'b11
   } cnt_e;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken && (cnt != CntSt)) begin
         nxt = cnt + 2'd1;
      end else if (!taken && (cnt != CntSnt)) begin
         nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

   // pc_word is the PC shifted right by 2; bits selects the history width.
   function automatic logic [15:0] pht_index(input logic [15:0] pc_word,
                                             input logic [15:0] ghr,
                                             input int unsigned bits);
      logic [15:0] mask;
      mask = 16'((32'd1 << bits) - 32'd1);
      return (pc_word ^ ghr) & mask;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous write.
// Only valid bits are reset; tags and targets are qualified by valid.
module bp_btb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned IDX_BITS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-3:0] lookup_word,
   output logic            hit,
   output logic [XLEN-1:0] target,
   input  logic            wr_en,
   input  logic [XLEN-3:0] wr_word,
   input  logic [XLEN-1:0] wr_target
);

   localparam int unsigned DEPTH    = 1 << IDX_BITS;
   localparam int unsigned TAG_BITS = XLEN - 2 - IDX_BITS;

   logic [DEPTH-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q    [DEPTH];
   logic [XLEN-1:0]     target_q [DEPTH];

   logic [IDX_BITS-1:0] lookup_idx, wr_idx;
   logic [TAG_BITS-1:0] lookup_tag, wr_tag;

   assign lookup_idx = lookup_word[IDX_BITS-1:0];
   assign lookup_tag = lookup_word[XLEN-3:IDX_BITS];
   assign wr_idx     = wr_word[IDX_BITS-1:0];
   assign wr_tag     = wr_word[XLEN-3:IDX_BITS];

   assign hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
   assign target = target_q[lookup_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/gshare_bpu.sv
// Gshare branch prediction unit: PHT, GHR and perf counters, with a BTB sub-block.
// Lookup is combinational; training from Execute resolution happens on the clock edge.
module gshare_bpu
   import bp_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned GHR_BITS     = GHR_BITS_DEF,
   parameter int unsigned BTB_IDX_BITS = BTB_IDX_BITS_DEF,
   parameter int unsigned CNT_BITS     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [XLEN-1:0]     fetch_pc,
   output logic [XLEN-1:0]     predicted_pc,
   output logic                prediction_valid,
   output logic [GHR_BITS-1:0] ghr_out,
   input  logic                branch_resolved,
   input  logic [XLEN-1:0]     resolved_pc,
   input  logic                branch_taken,
   input  logic [XLEN-1:0]     branch_addr,
   input  logic [GHR_BITS-1:0] ghr_history,
   input  logic                pc_redirect,
   output logic [CNT_BITS-1:0] branch_count,
   output logic [CNT_BITS-1:0] mispredict_count
);

   localparam int unsigned PHT_DEPTH = 1 << GHR_BITS;

   logic [1:0]          pht_q [PHT_DEPTH];
   logic [GHR_BITS-1:0] ghr_q;
   logic [CNT_BITS-1:0] branch_cnt_q, mispred_cnt_q;

   logic [GHR_BITS-1:0] lookup_idx, update_idx;
   logic                btb_hit;
   logic [XLEN-1:0]     btb_target;
   logic                unused_pc_low;

   assign unused_pc_low = ^resolved_pc[1:0];

   assign lookup_idx = GHR_BITS'(pht_index(16'(fetch_pc >> 2), 16'(ghr_q), GHR_BITS));
   assign update_idx = GHR_BITS'(pht_index(16'(resolved_pc >> 2), 16'(ghr_history), GHR_BITS));

   bp_btb #(
      .XLEN     (XLEN),
      .IDX_BITS (BTB_IDX_BITS)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lookup_word (fetch_pc[XLEN-1:2]),
      .hit         (btb_hit),
      .target      (btb_target),
      .wr_en       (branch_resolved & branch_taken),
      .wr_word     (resolved_pc[XLEN-1:2]),
      .wr_target   (branch_addr)
   );

   assign prediction_valid = btb_hit & pht_q[lookup_idx][1];
   assign predicted_pc     = prediction_valid ? btb_target : fetch_pc + XLEN'(4);
   assign ghr_out          = ghr_q;
   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispred_cnt_q;

   // History is rebuilt from the carried snapshot, which also repairs it after a mispredict.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) begin
            pht_q[i] <= CntWnt;
         end
         ghr_q         <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (branch_resolved) begin
         pht_q[update_idx] <= sat_update(pht_q[update_idx], branch_taken);
         ghr_q             <= {ghr_history[GHR_BITS-2:0], branch_taken};
         if (!(&branch_cnt_q)) begin
            branch_cnt_q <= branch_cnt_q + CNT_BITS'(1);
         end
         if (pc_redirect && !(&mispred_cnt_q)) begin
            mispred_cnt_q <= mispred_cnt_q + CNT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_gshare_bpu.sv
// Directed self-checking bench for gshare_bpu with 4-bit perf counters.
module tb_gshare_bpu;

   logic        clk;
   logic        rst;
   logic [31:0] fetch_pc;
   logic [31:0] predicted_pc;
   logic        prediction_valid;
   logic [3:0]  ghr_out;
   logic        branch_resolved;
   logic [31:0] resolved_pc;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  ghr_history;
   logic        pc_redirect;
   logic [3:0]  branch_count;
   logic [3:0]  mispredict_count;

   int tests_run;
   int tests_failed;

   gshare_bpu #(
      .XLEN         (32),
      .GHR_BITS     (4),
      .BTB_IDX_BITS (4),
      .CNT_BITS     (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_pc         (fetch_pc),
      .predicted_pc     (predicted_pc),
      .prediction_valid (prediction_valid),
      .ghr_out          (ghr_out),
      .branch_resolved  (branch_resolved),
      .resolved_pc      (resolved_pc),
      .branch_taken     (branch_taken),
      .branch_addr      (branch_addr),
      .ghr_history      (ghr_history),
      .pc_redirect      (pc_redirect),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      branch_resolved = 1'b0;
      pc_redirect = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                          input logic [3:0] hist, input logic redirect);
      branch_resolved = 1'b1;
      resolved_pc = pc;
      branch_taken = taken;
      branch_addr = target;
      ghr_history = hist;
      pc_redirect = redirect;
      @(posedge clk);
      #1;
      branch_resolved = 1'b0;
      pc_redirect = 1'b0;
   endtask

   task automatic set_fetch(input logic [31:0] pc);
      fetch_pc = pc;
      #1;
   endtask

   task automatic test_reset();
      fetch_pc = 32'h100;
      do_reset();
      #1;
      tests_run++;
      if (predicted_pc !== 32'h104) begin
         tests_failed++;
         $display("FAIL reset_pred_pc: got %h expected %h", predicted_pc, 32'h104);
      end
      tests_run++;
      if (prediction_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_pv: got %b expected 0", prediction_valid);
      end
      tests_run++;
      if (ghr_out !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_ghr: got %h expected 0", ghr_out);
      end
      tests_run++;
      if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count);
      end
   endtask

   task automatic test_taken_training();
      // PHT[0] WNT->WT, ghr=0001
      resolve(32'h100, 1'b1, 32'h200, 4'h0, 1'b1);
      set_fetch(32'h100);
      tests_run++;
      if (ghr_out !== 4'h1) begin
         tests_failed++;
         $display("FAIL train_ghr1: got %h expected 1", ghr_out);
      end
      tests_run++;
      if (branch_count !== 4'd1 || mispredict_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL train_counts1: got %0d/%0d expected 1/1", branch_count, mispredict_count);
      end
      tests_run++;
      if (prediction_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL train_pv_idx1: got %b expected 0", prediction_valid);
      end
      // PHT[1] WNT->WT, ghr=0011
      resolve(32'h100, 1'b1, 32'h200, 4'h1, 1'b0);
      set_fetch(32'h100);
      tests_run++;
      if (ghr_out !== 4'h3) begin
         tests_failed++;
         $display("FAIL train_ghr3: got %h expected 3", ghr_out);
      end
      tests_run++;
      if (prediction_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL train_pv_idx3: got %b expected 0", prediction_valid);
      end
      // Not-taken at an unrelated index brings ghr back to 0000
      resolve(32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
      set_fetch(32'h100);
      tests_run++;
      if (ghr_out !== 4'h0) begin
         tests_failed++;
         $display("FAIL train_ghr0: got %h expected 0", ghr_out);
      end
      tests_run++;
      if (prediction_valid !== 1'b1 || predicted_pc !== 32'h200) begin
         tests_failed++;
         $display("FAIL train_predict: got pv=%b pc=%h expected pv=1 pc=%h",
                  prediction_valid, predicted_pc, 32'h200);
      end
      tests_run++;
      if (branch_count !== 4'd3 || mispredict_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL train_counts3: got %0d/%0d expected 3/1", branch_count, mispredict_count);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         resolve(32'h100, 1'b1, 32'h200, 4'h0, 1'b0);
      end
      // 11 -> 10, ghr=0000
      resolve(32'h100, 1'b0, 32'h0, 4'h0, 1'b0);
      set_fetch(32'h100);
      tests_run++;
      if (prediction_valid !== 1'b1 || predicted_pc !== 32'h200) begin
         tests_failed++;
         $display("FAIL sat_still_taken: got pv=%b pc=%h expected pv=1 pc=%h",
                  prediction_valid, predicted_pc, 32'h200);
      end
      // 10 -> 01
      resolve(32'h100, 1'b0, 32'h0, 4'h0, 1'b0);
      set_fetch(32'h100);
      tests_run++;
      if (prediction_valid !== 1'b0 || predicted_pc !== 32'h104) begin
         tests_failed++;
         $display("FAIL sat_now_nt: got pv=%b pc=%h expected pv=0 pc=%h",
                  prediction_valid, predicted_pc, 32'h104);
      end
      tests_run++;
      if (branch_count !== 4'd6) begin
         tests_failed++;
         $display("FAIL sat_count: got %0d expected 6", branch_count);
      end
   endtask

   task automatic test_btb_conflict();
      do_reset();
      resolve(32'h100, 1'b1, 32'h200, 4'h0, 1'b0);
      resolve(32'h140, 1'b1, 32'h300, 4'h0, 1'b0);
      resolve(32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
      set_fetch(32'h100);
      tests_run++;
      if (prediction_valid !== 1'b0 || predicted_pc !== 32'h104) begin
         tests_failed++;
         $display("FAIL btb_evicted: got pv=%b pc=%h expected pv=0 pc=%h",
                  prediction_valid, predicted_pc, 32'h104);
      end
      set_fetch(32'h140);
      tests_run++;
      if (prediction_valid !== 1'b1 || predicted_pc !== 32'h300) begin
         tests_failed++;
         $display("FAIL btb_new_owner: got pv=%b pc=%h expected pv=1 pc=%h",
                  prediction_valid, predicted_pc, 32'h300);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      resolve(32'h100, 1'b1, 32'h200, 4'h0, 1'b0);
      resolve(32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
      // PHT[0] is WT; resolve it not-taken while looking it up
      fetch_pc = 32'h100;
      branch_resolved = 1'b1;
      resolved_pc = 32'h100;
      branch_taken = 1'b0;
      branch_addr = 32'h0;
      ghr_history = 4'h0;
      #1;
      tests_run++;
      if (prediction_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL same_pht_pre: got %b expected 1", prediction_valid);
      end
      @(posedge clk);
      #1;
      branch_resolved = 1'b0;
      #1;
      tests_run++;
      if (prediction_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL same_pht_post: got %b expected 0", prediction_valid);
      end
      resolve(32'h100, 1'b1, 32'h200, 4'h0, 1'b0);
      resolve(32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
      // BTB slot owned by 0x100; overwrite it with 0x140 while fetching 0x140
      fetch_pc = 32'h140;
      branch_resolved = 1'b1;
      resolved_pc = 32'h140;
      branch_taken = 1'b1;
      branch_addr = 32'h300;
      ghr_history = 4'h0;
      #1;
      tests_run++;
      if (prediction_valid !== 1'b0 || predicted_pc !== 32'h144) begin
         tests_failed++;
         $display("FAIL same_btb_pre: got pv=%b pc=%h expected pv=0 pc=%h",
                  prediction_valid, predicted_pc, 32'h144);
      end
      @(posedge clk);
      #1;
      branch_resolved = 1'b0;
      resolve(32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
      set_fetch(32'h140);
      tests_run++;
      if (prediction_valid !== 1'b1 || predicted_pc !== 32'h300) begin
         tests_failed++;
         $display("FAIL same_btb_post: got pv=%b pc=%h expected pv=1 pc=%h",
                  prediction_valid, predicted_pc, 32'h300);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // Redirect without a resolution must be ignored
      pc_redirect = 1'b1;
      @(posedge clk);
      #1;
      pc_redirect = 1'b0;
      tests_run++;
      if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL idle_redirect: got %0d/%0d expected 0/0", branch_count, mispredict_count);
      end
      for (int i = 0; i < 20; i++) begin
         branch_resolved = 1'b1;
         resolved_pc = 32'h100;
         branch_taken = 1'b1;
         branch_addr = 32'h200;
         ghr_history = 4'h0;
         pc_redirect = (i < 18);
         @(posedge clk);
         #1;
         if (i == 4) begin
            tests_run++;
            if (branch_count !== 4'd5 || mispredict_count !== 4'd5) begin
               tests_failed++;
               $display("FAIL b2b_counts5: got %0d/%0d expected 5/5",
                        branch_count, mispredict_count);
            end
         end
      end
      branch_resolved = 1'b0;
      pc_redirect = 1'b0;
      tests_run++;
      if (branch_count !== 4'd15) begin
         tests_failed++;
         $display("FAIL cnt_sat_branch: got %0d expected 15", branch_count);
      end
      tests_run++;
      if (mispredict_count !== 4'd15) begin
         tests_failed++;
         $display("FAIL cnt_sat_mispred: got %0d expected 15", mispredict_count);
      end
   endtask

   task automatic test_mid_reset();
      // Resolution coinciding with reset must be dropped
      rst = 1'b1;
      branch_resolved = 1'b1;
      resolved_pc = 32'h100;
      branch_taken = 1'b1;
      branch_addr = 32'h200;
      ghr_history = 4'h7;
      pc_redirect = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      branch_resolved = 1'b0;
      pc_redirect = 1'b0;
      set_fetch(32'h100);
      tests_run++;
      if (ghr_out !== 4'h0) begin
         tests_failed++;
         $display("FAIL midrst_ghr: got %h expected 0", ghr_out);
      end
      tests_run++;
      if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL midrst_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count);
      end
      tests_run++;
      if (prediction_valid !== 1'b0 || predicted_pc !== 32'h104) begin
         tests_failed++;
         $display("FAIL midrst_predict: got pv=%b pc=%h expected pv=0 pc=%h",
                  prediction_valid, predicted_pc, 32'h104);
      end
      // Refill BTB via PHT[8], return ghr to 0: PHT[0] must be back at WNT
      resolve(32'h100, 1'b1, 32'h200, 4'h8, 1'b0);
      resolve(32'h108, 1'b0, 32'h0, 4'h0, 1'b0);
      set_fetch(32'h100);
      tests_run++;
      if (prediction_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_pht_cleared: got %b expected 0", prediction_valid);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b0;
      fetch_pc = 32'h0;
      branch_resolved = 1'b0;
      resolved_pc = 32'h0;
      branch_taken = 1'b0;
      branch_addr = 32'h0;
      ghr_history = 4'h0;
      pc_redirect = 1'b0;
      test_reset();
      test_taken_training();
      test_saturation();
      test_btb_conflict();
      test_same_cycle();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
